ext_line_memory: RTL and testbench



---
 rtl/ext_mem_pkg.sv | 15 +
 rtl/ext_mem_line_array.sv | 34 +++
 rtl/ext_line_memory.sv | 114 +++++++++++
 tb/tb_ext_line_memory.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared external-memory definitions: FSM encoding and line geometry,
// also used by the L1 cache controller and its bench.
package ext_mem_pkg;

  localparam int LINE_W          = 256;
  localparam int LINE_OFF_W      = 5;
  localparam int DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/ext_mem_line_array.sv
// DEPTH_LINES x LINE_W line storage: synchronous write, registered read.
// Contents are not reset; only the read register is.
module ext_mem_line_array
  import ext_mem_pkg::*;
#(
  parameter int LINE_W      = ext_mem_pkg::LINE_W,
  parameter int DEPTH_LINES = 512,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH_LINES];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[idx_i] <= wdata_i;
  end

  // Read register holds the last read line until the next read commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rdata_q <= '0;
    else if (rd_en_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_line_memory.sv
// Line-granular external data memory with fixed access latency (cs/we/ack).
// Optional read/write counters under EXT_LINE_MEMORY_STATS_EN.
module ext_line_memory
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = ext_mem_pkg::LINE_W,
  parameter int DEPTH_LINES = 512,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_cs_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_ack_o,
`ifdef EXT_LINE_MEMORY_STATS_EN
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o,
`endif
  output logic              mem_busy_o
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  mem_state_e        state_q;
  logic [7:0]        cnt_q;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              ack_q;
  logic              busy_q;
  logic              commit;
  logic              unused_addr;

  assign unused_addr = ^{mem_addr_i[ADDR_W-1:IDX_W+LINE_OFF_W], mem_addr_i[LINE_OFF_W-1:0]};

  // The access lands on the edge the counter is seen at zero, which is also the ack-rise edge.
  assign commit = (state_q == WAIT) && (cnt_q == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mem_cs_i) begin
          we_q    <= mem_we_i;
          idx_q   <= mem_addr_i[IDX_W+LINE_OFF_W-1:LINE_OFF_W];
          wdata_q <= mem_data_i;
          cnt_q   <= 8'(LATENCY - 1);
          busy_q  <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == 8'd0) begin
          ack_q   <= 1'b1;
          state_q <= ACK;
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
        // A still-asserted cs is ignored here, so a held request re-accepts one edge after ack falls.
        ACK: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ext_mem_line_array #(
    .LINE_W      (LINE_W),
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (commit & we_q),
    .rd_en_i (commit & ~we_q),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_data_o)
  );

  assign mem_ack_o  = ack_q;
  assign mem_busy_o = busy_q;

`ifdef EXT_LINE_MEMORY_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else if (commit) begin
      if (!we_q && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      if ( we_q && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_ext_line_memory.sv
// Bench for ext_line_memory: LATENCY=10 instance plus a LATENCY=1 instance.
module tb_ext_line_memory;
  import ext_mem_pkg::*;

  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              cs = 1'b0, we = 1'b0;
  logic [31:0]       addr = '0;
  logic [LINE_W-1:0] wdata = '0;
  logic [LINE_W-1:0] data0;
  logic              ack0, busy0;

  logic              cs1 = 1'b0, we1 = 1'b0;
  logic [31:0]       addr1 = '0;
  logic [LINE_W-1:0] wdata1 = '0;
  logic [LINE_W-1:0] data1;
  logic              ack1, busy1;

`ifdef EXT_LINE_MEMORY_STATS_EN
  logic [31:0] rdc0, wrc0, rdc1, wrc1;
`endif

  ext_line_memory #(.LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mem_cs_i(cs), .mem_we_i(we), .mem_addr_i(addr),
    .mem_data_i(wdata), .mem_data_o(data0), .mem_ack_o(ack0),
`ifdef EXT_LINE_MEMORY_STATS_EN
    .rd_count_o(rdc0), .wr_count_o(wrc0),
`endif
    .mem_busy_o(busy0)
  );

  ext_line_memory #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_cs_i(cs1), .mem_we_i(we1), .mem_addr_i(addr1),
    .mem_data_i(wdata1), .mem_data_o(data1), .mem_ack_o(ack1),
`ifdef EXT_LINE_MEMORY_STATS_EN
    .rd_count_o(rdc1), .wr_count_o(wrc1),
`endif
    .mem_busy_o(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [LINE_W-1:0] exp_q[$];

  localparam logic [LINE_W-1:0] DB = {8{32'hDEAD_BEEF}};
  localparam logic [LINE_W-1:0] DA = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] DC = {8{32'hC0C0_C0C0}};
  localparam logic [LINE_W-1:0] DE = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [LINE_W-1:0] DBB = {8{32'hBBBB_0000}};
  localparam logic [LINE_W-1:0] DD = {8{32'h0D0D_1111}};
  localparam logic [LINE_W-1:0] DF = {8{32'hF00D_2222}};

  typedef struct {
    logic              we;
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic [LINE_W-1:0] exp;   // mem_data_o during the ack cycle
  } vec_t;

  task automatic check(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [LINE_W-1:0] d,
                        input logic [LINE_W-1:0] exp, input string nm);
    int k;
    @(negedge clk);
    cs = 1'b1; we = w; addr = a; wdata = d;
    exp_q.push_back(exp);
    @(negedge clk);
    check({nm, " busy"}, busy0, 1);
    // Scramble request fields and drop cs: the access must still complete unchanged.
    cs = 1'b0; we = ~w; addr = a ^ 32'h0000_0FE0; wdata = ~d;
    k = 0;
    while (!ack0 && k < 3 * LAT + 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, k, LAT);
    if (ack0) check({nm, " data"}, data0, exp_q.pop_front());
    else void'(exp_q.pop_front());
    @(negedge clk);
    check({nm, " ack fall"}, ack0, 0);
    check({nm, " busy fall"}, busy0, 0);
    check({nm, " data hold"}, data0, exp);
  endtask

  task automatic access1(input logic w, input logic [31:0] a, input logic [LINE_W-1:0] d,
                         input logic [LINE_W-1:0] exp);
    int k;
    @(negedge clk);
    cs1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    exp_q.push_back(exp);
    @(negedge clk);
    cs1 = 1'b0;
    k = 0;
    while (!ack1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("lat1 latency", k, 1);
    if (ack1) check("lat1 data", data1, exp_q.pop_front());
    else void'(exp_q.pop_front());
    @(negedge clk);
    check("lat1 ack fall", ack1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   ack_at[$];

    vecs[0] = '{1'b1, 32'h0000_0040, DB, '0};
    vecs[1] = '{1'b0, 32'h0000_0040, '0, DB};
    vecs[2] = '{1'b1, 32'h0000_0020, DA, DB};
    vecs[3] = '{1'b0, 32'h0000_4020, '0, DA};
    vecs[4] = '{1'b0, 32'h0000_003F, '0, DA};
    vecs[5] = '{1'b1, 32'h0000_0080, DC, DA};
    vecs[6] = '{1'b0, 32'h0000_0080, '0, DC};
    vecs[7] = '{1'b0, 32'h0000_0040, '0, DB};
    vecs[8] = '{1'b1, 32'hFFFF_C040, DE, DB};
    vecs[9] = '{1'b0, 32'h0000_0040, '0, DE};

    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle ack", ack0, 0);
      check("idle busy", busy0, 0);
      check("idle data", data0, 0);
    end

    for (int i = 0; i < 10; i++)
      access(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

    // cs held high: accept E0, ack after E10, idle at E11, re-accept E12, ...
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = 32'h0000_0040;
    repeat (3) exp_q.push_back(DE);
    for (int e = 0; e < 36; e++) begin
      @(negedge clk);
      if (ack0) begin
        ack_at.push_back(e);
        check("hold data", data0, exp_q.pop_front());
      end
    end
    cs = 1'b0;
    check("hold ack count", ack_at.size(), 3);
    if (ack_at.size() == 3) begin
      check("hold ack1 edge", ack_at[0], 10);
      check("hold ack2 edge", ack_at[1], 22);
      check("hold ack3 edge", ack_at[2], 34);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);

    // Reset asserted just before E5 of a write of B over C at 0x80.
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 32'h0000_0080; wdata = DBB;
    repeat (5) @(negedge clk);
    cs = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst ack", ack0, 0);
    check("rst busy", busy0, 0);
    check("rst data", data0, 0);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("post-rst no ack", ack0, 0);
    end
    access(1'b0, 32'h0000_0080, '0, DC, "rst read-back");

    // LATENCY=1 instance
    access1(1'b1, 32'h0000_0100, DD, '0);
    access1(1'b1, 32'h0000_0120, DF, '0);
    access1(1'b0, 32'h0000_0100, '0, DD);
    access1(1'b0, 32'h0000_0120, '0, DF);
    access1(1'b0, 32'h0004_0100, '0, DD);

`ifdef EXT_LINE_MEMORY_STATS_EN
    check("lat1 rd_count", rdc1, 3);
    check("lat1 wr_count", wrc1, 2);
    check("lat10 rd_count", rdc0, 1);
    check("lat10 wr_count", wrc0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
